// File: rtl/mux_arb_if.sv
// Handshake bundle between the N-channel source side and the single registered
// output of mux_arb.
interface mux_arb_if #(
  parameter int W  = 8,
  parameter int N  = 8,
  parameter int SW = 3
);
  logic            mode;
  logic [SW-1:0]   s;
  logic [N-1:0]    i_valid;
  logic [N*W-1:0]  i_data;
  logic [N-1:0]    i_ready;
  logic            y_valid;
  logic [W-1:0]    y_data;
  logic [SW-1:0]   y_ch;
  logic            y_ready;

  modport slave  (input  mode, s, i_valid, i_data, y_ready,
                  output i_ready, y_valid, y_data, y_ch);
  modport master (output mode, s, i_valid, i_data, y_ready,
                  input  i_ready, y_valid, y_data, y_ch);
endinterface

// File: rtl/mux_arb.sv
// N-to-1 arbitrating mux with a single registered output stage.
// The grant is either a fixed select (mode=0) or round-robin after ptr (mode=1).
module mux_arb_lane #(
  parameter int W   = 8,
  parameter int SW  = 3,
  parameter int IDX = 0
) (
  input  logic          load,
  input  logic          gnt_vld,
  input  logic [SW-1:0] gnt_idx,
  input  logic [W-1:0]  data,
  output logic          ready,
  output logic [W-1:0]  data_m
);
  assign ready  = load & gnt_vld & (gnt_idx == SW'(IDX));
  assign data_m = ready ? data : '0;
endmodule

module mux_arb #(
  parameter int W  = 8,
  parameter int N  = 8,
  parameter int SW = 3
) (
  input logic       clk,
  input logic       rst_n,
  mux_arb_if.slave  bus
);
  localparam int NP = 1 << SW;

  logic                    y_valid_q, y_valid_d;
  logic [W-1:0]            y_data_q,  y_data_d;
  logic [SW-1:0]           y_ch_q,    y_ch_d;
  logic [SW-1:0]           ptr_q,     ptr_d;

  logic                    load;
  logic                    fx_vld, rr_vld, gnt_vld;
  logic [SW-1:0]           rr_idx, gnt_idx;
  logic [NP-1:0]           vpad;
  logic [N-1:0]            ready;
  logic [N-1:0][W-1:0]     data_m;
  logic [W-1:0]            data_or;
  int                      c;

  assign load = rst_n & (~y_valid_q | bus.y_ready);

  // Padding lets an out-of-range select index safely read a zero.
  assign vpad   = NP'(bus.i_valid);
  assign fx_vld = (int'(bus.s) < N) && vpad[bus.s];

  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    c      = 0;
    for (int off = 1; off <= N; off++) begin
      c = (int'(ptr_q) + off) % N;
      if (!rr_vld && bus.i_valid[c]) begin
        rr_vld = 1'b1;
        rr_idx = SW'(c);
      end
    end
  end

  assign gnt_vld = bus.mode ? rr_vld : fx_vld;
  assign gnt_idx = bus.mode ? rr_idx : bus.s;

  for (genvar k = 0; k < N; k++) begin : g_lane
    mux_arb_lane #(.W(W), .SW(SW), .IDX(k)) u_lane (
      .load    (load),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx),
      .data    (bus.i_data[k*W +: W]),
      .ready   (ready[k]),
      .data_m  (data_m[k])
    );
  end

  // Lane outputs are one-hot masked, so an OR tree is the mux.
  always_comb begin
    data_or = '0;
    for (int k = 0; k < N; k++) data_or |= data_m[k];
  end

  always_comb begin
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_ch_d    = y_ch_q;
    ptr_d     = ptr_q;
    if (load) begin
      y_valid_d = gnt_vld;
      if (gnt_vld) begin
        y_data_d = data_or;
        y_ch_d   = gnt_idx;
        if (bus.mode) ptr_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_ch_q    <= '0;
      ptr_q     <= SW'(N - 1);
    end else begin
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_ch_q    <= y_ch_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.i_ready = ready;
  assign bus.y_valid = y_valid_q;
  assign bus.y_data  = y_data_q;
  assign bus.y_ch    = y_ch_q;
endmodule

// File: tb/tb_mux_arb.sv
// Directed checks of mux_arb: an 8-channel instance for most scenarios and a
// 6-channel instance for the out-of-range select case.
module tb_mux_arb;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] d8 [8];
  logic [7:0] d6 [6];

  always #5 clk = ~clk;

  mux_arb_if #(.W(8), .N(8), .SW(3)) b8 ();
  mux_arb_if #(.W(8), .N(6), .SW(3)) b6 ();

  mux_arb #(.W(8), .N(8), .SW(3)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  mux_arb #(.W(8), .N(6), .SW(3)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));

  task automatic pack();
    for (int k = 0; k < 8; k++) b8.i_data[k*8 +: 8] = d8[k];
    for (int k = 0; k < 6; k++) b6.i_data[k*8 +: 8] = d6[k];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; b8.mode = 1'b1; b8.i_valid = 8'hFF; b8.y_ready = 1'b1; pack();
    #1;
    n_cmp++; if (b8.i_ready !== 8'h00) begin n_err++; $display("FAIL reset_irdy: got %h want 00", b8.i_ready); end
    tick();
    n_cmp++; if (b8.y_valid !== 1'b0) begin n_err++; $display("FAIL reset_yvalid: got %b want 0", b8.y_valid); end
    n_cmp++; if (b8.y_data !== 8'h00) begin n_err++; $display("FAIL reset_ydata: got %h want 00", b8.y_data); end
    n_cmp++; if (b8.y_ch !== 3'd0) begin n_err++; $display("FAIL reset_ych: got %0d want 0", b8.y_ch); end
  endtask

  task automatic test_fixed();
    rst_n = 1'b1; b8.mode = 1'b0; b8.s = 3'd5; b8.i_valid = 8'hFF; b8.y_ready = 1'b1;
    #1;
    n_cmp++; if (b8.i_ready !== 8'h20) begin n_err++; $display("FAIL fixed_irdy: got %h want 20", b8.i_ready); end
    tick();
    n_cmp++; if (b8.y_valid !== 1'b1) begin n_err++; $display("FAIL fixed_yvalid: got %b want 1", b8.y_valid); end
    n_cmp++; if (b8.y_data !== 8'hA5) begin n_err++; $display("FAIL fixed_ydata: got %h want a5", b8.y_data); end
    n_cmp++; if (b8.y_ch !== 3'd5) begin n_err++; $display("FAIL fixed_ych: got %0d want 5", b8.y_ch); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    logic [7:0] exp_r;
    exp_g[0] = 3'd0; exp_g[1] = 3'd2; exp_g[2] = 3'd7; exp_g[3] = 3'd0;
    rst_n = 1'b0; tick();
    rst_n = 1'b1; b8.mode = 1'b1; b8.i_valid = 8'b1000_0101; b8.y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_r = 8'h01 << exp_g[i];
      n_cmp++; if (b8.i_ready !== exp_r) begin n_err++; $display("FAIL rr_irdy[%0d]: got %h want %h", i, b8.i_ready, exp_r); end
      tick();
      n_cmp++; if (b8.y_ch !== exp_g[i]) begin n_err++; $display("FAIL rr_ych[%0d]: got %0d want %0d", i, b8.y_ch, exp_g[i]); end
      n_cmp++; if (b8.y_data !== (8'hA0 | {5'd0, exp_g[i]})) begin n_err++; $display("FAIL rr_ydata[%0d]: got %h want %h", i, b8.y_data, 8'hA0 | {5'd0, exp_g[i]}); end
    end
  endtask

  task automatic test_stall();
    d8[3] = 8'h3C; pack();
    b8.mode = 1'b0; b8.s = 3'd3; b8.i_valid = 8'hFF; b8.y_ready = 1'b1;
    #1;
    n_cmp++; if (b8.i_ready !== 8'h08) begin n_err++; $display("FAIL stall_load_irdy: got %h want 08", b8.i_ready); end
    tick();
    n_cmp++; if (b8.y_data !== 8'h3C) begin n_err++; $display("FAIL stall_load_ydata: got %h want 3c", b8.y_data); end
    b8.y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b8.s = 3'(i); b8.mode = i[0]; d8[3] = 8'(8'h11 * i); pack();
      #1;
      n_cmp++; if (b8.i_ready !== 8'h00) begin n_err++; $display("FAIL stall_irdy[%0d]: got %h want 00", i, b8.i_ready); end
      tick();
      n_cmp++; if (b8.y_valid !== 1'b1 || b8.y_data !== 8'h3C || b8.y_ch !== 3'd3) begin
        n_err++; $display("FAIL stall_hold[%0d]: got v=%b d=%h ch=%0d want v=1 d=3c ch=3", i, b8.y_valid, b8.y_data, b8.y_ch); end
    end
    d8[3] = 8'hA3; pack();
    b8.mode = 1'b0; b8.s = 3'd6; b8.y_ready = 1'b1;
    #1;
    n_cmp++; if (b8.i_ready !== 8'h40) begin n_err++; $display("FAIL stall_release_irdy: got %h want 40", b8.i_ready); end
    tick();
    n_cmp++; if (b8.y_data !== 8'hA6 || b8.y_ch !== 3'd6) begin n_err++; $display("FAIL stall_release_y: got d=%h ch=%0d want d=a6 ch=6", b8.y_data, b8.y_ch); end
  endtask

  task automatic test_no_grant();
    b8.mode = 1'b0; b8.s = 3'd2; b8.i_valid = 8'h00; b8.y_ready = 1'b1;
    #1;
    n_cmp++; if (b8.i_ready !== 8'h00) begin n_err++; $display("FAIL nogrant_irdy: got %h want 00", b8.i_ready); end
    tick();
    n_cmp++; if (b8.y_valid !== 1'b0 || b8.y_data !== 8'hA6 || b8.y_ch !== 3'd6) begin
      n_err++; $display("FAIL nogrant_y: got v=%b d=%h ch=%0d want v=0 d=a6 ch=6", b8.y_valid, b8.y_data, b8.y_ch); end
  endtask

  task automatic test_reset_mid_stall();
    b8.mode = 1'b1; b8.i_valid = 8'h08; b8.y_ready = 1'b1;
    tick();
    n_cmp++; if (b8.y_valid !== 1'b1 || b8.y_ch !== 3'd3) begin n_err++; $display("FAIL rst_stall_pre: got v=%b ch=%0d want v=1 ch=3", b8.y_valid, b8.y_ch); end
    b8.y_ready = 1'b0; rst_n = 1'b0;
    #1;
    n_cmp++; if (b8.i_ready !== 8'h00) begin n_err++; $display("FAIL rst_stall_irdy: got %h want 00", b8.i_ready); end
    tick();
    n_cmp++; if (b8.y_valid !== 1'b0 || b8.y_data !== 8'h00 || b8.y_ch !== 3'd0) begin
      n_err++; $display("FAIL rst_stall_y: got v=%b d=%h ch=%0d want v=0 d=00 ch=0", b8.y_valid, b8.y_data, b8.y_ch); end
    rst_n = 1'b1; b8.i_valid = 8'hFF; b8.y_ready = 1'b1;
    #1;
    n_cmp++; if (b8.i_ready !== 8'h01) begin n_err++; $display("FAIL rst_stall_restart: got %h want 01", b8.i_ready); end
    tick();
  endtask

  task automatic test_mode_switch();
    b8.mode = 1'b1; b8.i_valid = 8'h08; b8.y_ready = 1'b1;
    #1;
    n_cmp++; if (b8.i_ready !== 8'h08) begin n_err++; $display("FAIL mswitch_rr3: got %h want 08", b8.i_ready); end
    tick();
    b8.mode = 1'b0; b8.s = 3'd1; b8.i_valid = 8'hFF;
    #1;
    n_cmp++; if (b8.i_ready !== 8'h02) begin n_err++; $display("FAIL mswitch_fixed_irdy: got %h want 02", b8.i_ready); end
    tick();
    n_cmp++; if (b8.y_data !== 8'hA1 || b8.y_ch !== 3'd1) begin n_err++; $display("FAIL mswitch_fixed_y: got d=%h ch=%0d want d=a1 ch=1", b8.y_data, b8.y_ch); end
    b8.mode = 1'b1;
    #1;
    n_cmp++; if (b8.i_ready !== 8'h10) begin n_err++; $display("FAIL mswitch_rr_resume: got %h want 10", b8.i_ready); end
    tick();
    n_cmp++; if (b8.y_ch !== 3'd4) begin n_err++; $display("FAIL mswitch_rr_ych: got %0d want 4", b8.y_ch); end
  endtask

  task automatic test_invalid_select();
    b6.mode = 1'b0; b6.s = 3'd2; b6.i_valid = 6'h3F; b6.y_ready = 1'b1;
    #1;
    n_cmp++; if (b6.i_ready !== 6'h04) begin n_err++; $display("FAIL badsel_pre_irdy: got %h want 04", b6.i_ready); end
    tick();
    b6.s = 3'd7; b6.y_ready = 1'b0;
    #1;
    n_cmp++; if (b6.i_ready !== 6'h00) begin n_err++; $display("FAIL badsel_stall_irdy: got %h want 00", b6.i_ready); end
    tick();
    n_cmp++; if (b6.y_valid !== 1'b1 || b6.y_data !== 8'h62 || b6.y_ch !== 3'd2) begin
      n_err++; $display("FAIL badsel_hold: got v=%b d=%h ch=%0d want v=1 d=62 ch=2", b6.y_valid, b6.y_data, b6.y_ch); end
    b6.y_ready = 1'b1;
    #1;
    n_cmp++; if (b6.i_ready !== 6'h00) begin n_err++; $display("FAIL badsel_irdy: got %h want 00", b6.i_ready); end
    tick();
    n_cmp++; if (b6.y_valid !== 1'b0 || b6.y_ch !== 3'd2) begin n_err++; $display("FAIL badsel_drain: got v=%b ch=%0d want v=0 ch=2", b6.y_valid, b6.y_ch); end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) d8[k] = 8'hA0 | 8'(k);
    for (int k = 0; k < 6; k++) d6[k] = 8'h60 | 8'(k);
    rst_n = 1'b0;
    b8.mode = 1'b0; b8.s = '0; b8.i_valid = '0; b8.i_data = '0; b8.y_ready = 1'b0;
    b6.mode = 1'b0; b6.s = '0; b6.i_valid = '0; b6.i_data = '0; b6.y_ready = 1'b1;
    pack();
    tick();
    test_reset();
    test_fixed();
    test_round_robin();
    test_stall();
    test_no_grant();
    test_reset_mid_stall();
    test_mode_switch();
    test_invalid_select();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 The block SHALL have parameter W, default 8, data width per channel in bits (W >= 1).
REQ-002 The block SHALL have parameter N, default 8, number of input channels (2 <= N <= 64).
REQ-003 The block SHALL have parameter SW, default 3, select/channel-index width, equal to ceil(log2(N)).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = fixed select by s, 1 = round-robin.
REQ-007 The block SHALL have port s, input, SW bits: channel select used when mode=0.
REQ-008 The block SHALL have port i_valid, input, N bits: per-channel beat-valid flags.
REQ-009 The block SHALL have port i_data, input, N*W bits: channel k occupies bits [k*W+W-1 : k*W].
REQ-010 The block SHALL have port i_ready, output, N bits: per-channel accept flags, combinational.
REQ-011 The block SHALL have port y_valid, output, 1 bit: the output register holds a beat.
REQ-012 The block SHALL have port y_data, output, W bits: registered output data.
REQ-013 The block SHALL have port y_ch, output, SW bits: source channel index of the beat in y_data.
REQ-014 The block SHALL have port y_ready, input, 1 bit: downstream accepts the beat when y_valid=1 and y_ready=1.

Function
REQ-015 The block SHALL define load = rst_n & (~y_valid | y_ready); a transfer from a channel occurs only when load=1.
REQ-016 In mode=0, the grant SHALL be channel s when s < N and i_valid[s]=1; otherwise there SHALL be no grant.
REQ-017 In mode=1, the grant SHALL be the first channel with i_valid=1, searching ptr+1, ptr+2, ... modulo N, ending at ptr itself.
REQ-018 When no grant exists, all i_ready bits SHALL be 0.
REQ-019 i_ready[k] SHALL be 1 only when load=1 and k is the granted channel; at most one i_ready bit SHALL be high in any cycle.
REQ-020 On a transfer, the next edge SHALL set y_valid=1, y_data=i_data of the granted channel, and y_ch=the granted index.
REQ-021 Latency from input acceptance to y_valid SHALL be exactly 1 cycle.
REQ-022 Sustained throughput SHALL be 1 beat per cycle while y_ready=1 and a grant exists.
REQ-023 When load=1 with no grant, the next edge SHALL clear y_valid and hold y_data and y_ch unchanged.
REQ-024 When y_valid=1 and y_ready=0 (stall), y_valid, y_data and y_ch SHALL hold, and i_ready SHALL be 0.
REQ-025 The internal round-robin pointer ptr (SW bits) SHALL update to the granted index on every transfer in mode=1.
REQ-026 ptr SHALL be left unchanged on transfers in mode=0.
REQ-027 A change of mode or s SHALL affect only the next grant and SHALL NOT modify a held output beat.
REQ-028 Round-robin wrap: after a grant to channel N-1, the search SHALL start at channel 0.
REQ-029 The block SHALL contain no combinational path from y_ready to y_data or y_valid.
REQ-030 The path from y_ready and i_valid to i_ready SHALL be combinational.

Reset
REQ-031 While rst_n=0 at a rising edge, the block SHALL set y_valid=0, y_data=0, y_ch=0, and ptr=N-1, so that the first round-robin search starts at channel 0.
REQ-032 While rst_n=0, i_ready SHALL be all-zero.
REQ-033 An assertion of reset during a held or stalled beat SHALL discard that beat with no output transfer.
REQ-034 The first transfer after reset SHALL be possible in the first cycle with rst_n=1.

Verification
REQ-035 Fixed mode: N=8, W=8, mode=0, s=5, i_valid=8'hFF, channel 5 data 8'hA5, y_ready=1 -> i_ready=8'h20; next cycle y_valid=1, y_data=8'hA5, y_ch=5.
REQ-036 Round-robin: after reset, mode=1, i_valid=8'b1000_0101, y_ready=1 for 4 cycles -> grants in order 0, 2, 7, 0, with y_ch following one cycle later.
REQ-037 Stall: y_valid=1, y_data=8'h3C, y_ready=0 for 3 cycles with inputs changing -> y_data stays 8'h3C and i_ready=0; first cycle with y_ready=1 loads the next beat.
REQ-038 Invalid select: N=6, SW=3, mode=0, s=7, i_valid all high -> i_ready=0; y_valid drops to 0 after the held beat drains.
REQ-039 Reset mid-stall: y_valid=1, y_ready=0, rst_n=0 for 1 edge -> y_valid=0, y_data=0, y_ch=0; round-robin restarts at channel 0.
REQ-040 Mode switch: after a mode=1 grant to channel 3, switch to mode=0 with s=1, then return to mode=1 -> channel 1 is granted in fixed mode, and the next round-robin search starts at channel 4.
